// File: rtl/stim_channel_scheduler_if.sv
// Amplitude-memory read port and per-channel SPI load side of stim_channel_scheduler.
interface stim_channel_scheduler_if #(
  parameter int unsigned N_CH = 12
);
  logic            mem_rd_en;
  logic [3:0]      mem_rd_ch;
  logic [15:0]     mem_rd_data;
  logic [N_CH-1:0] spi_busy;
  logic [N_CH-1:0] load;
  logic [15:0]     data_out;

  modport master (
    output mem_rd_en, mem_rd_ch, load, data_out,
    input  mem_rd_data, spi_busy
  );

  modport slave (
    input  mem_rd_en, mem_rd_ch, load, data_out,
    output mem_rd_data, spi_busy
  );
endinterface

// File: rtl/stim_channel_scheduler.sv
// Per-channel pulse sequencing with round-robin access to the shared amplitude memory.
// Optional STIM_SCHED_OVERRUN_EN: flag period expiries that land while a pulse is still pending.
module stim_channel_scheduler #(
  parameter int unsigned N_CH  = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [CNT_W-1:0]         period,
  input  logic [CNT_W-1:0]         num_of_pulses,
  input  logic                     tick,
  output logic [N_CH-1:0]          done,
  output logic [N_CH-1:0]          overrun,
  output logic                     active,
  stim_channel_scheduler_if.master bus
);
  localparam int unsigned      IDX_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PEND, S_ISSUE, S_DONE} ch_state_e;

  ch_state_e        state_q [N_CH];
  ch_state_e        state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W-1:0] pcnt_q  [N_CH];
  logic [CNT_W-1:0] pcnt_d  [N_CH];

  logic             enable_q;
  logic             rise;
  logic [CNT_W-1:0] reload;
  logic [IDX_W-1:0] last_q;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  int unsigned      cand;
  logic             rd_vld_q;
  logic [IDX_W-1:0] rd_ch_q;
  logic [N_CH-1:0]  load_q;
  logic [15:0]      data_q;

  assign rise   = enable & ~enable_q;
  assign reload = (period == '0) ? ONE : period;

  // Round-robin search starting just after the most recently granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!gnt_vld && enable && state_q[IDX_W'(cand)] == S_PEND &&
          !bus.spi_busy[IDX_W'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  assign bus.mem_rd_en = gnt_vld;
  assign bus.mem_rd_ch = 4'(gnt_idx);
  assign bus.load      = load_q;
  assign bus.data_out  = data_q;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      enable_q <= 1'b0;
      last_q   <= IDX_W'(N_CH - 1);
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
      load_q   <= '0;
      data_q   <= '0;
    end else begin
      enable_q <= 1'b1;
      rd_vld_q <= gnt_vld;
      if (gnt_vld) begin
        rd_ch_q <= gnt_idx;
        last_q  <= gnt_idx;
      end
      load_q <= '0;
      if (rd_vld_q) begin
        load_q[rd_ch_q] <= 1'b1;
        data_q          <= bus.mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rst) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        pcnt_q[i]  <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pcnt_q[i]  <= pcnt_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pcnt_d[i]  = pcnt_q[i];
      if (!enable) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        pcnt_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          S_IDLE: begin
            if (rise && ch_en[i]) begin
              state_d[i] = S_PEND;
              cnt_d[i]   = reload;
            end
          end
          S_WAIT: begin
            if (tick) begin
              if (cnt_q[i] <= ONE) begin
                state_d[i] = S_PEND;
                cnt_d[i]   = reload;
              end else begin
                cnt_d[i] = cnt_q[i] - ONE;
              end
            end
          end
          S_PEND, S_ISSUE: begin
            // The period keeps running while a pulse is pending; a coincident load
            // restarts it and swallows any tick in the same cycle.
            if (state_q[i] == S_ISSUE && load_q[i]) begin
              cnt_d[i] = reload;
              if (pcnt_q[i] != '1) pcnt_d[i] = pcnt_q[i] + ONE;
              if (num_of_pulses != '0 && pcnt_d[i] >= num_of_pulses) state_d[i] = S_DONE;
              else state_d[i] = S_WAIT;
            end else begin
              if (gnt_vld && gnt_idx == IDX_W'(i)) state_d[i] = S_ISSUE;
              if (tick) begin
                if (cnt_q[i] <= ONE) cnt_d[i] = reload;
                else cnt_d[i] = cnt_q[i] - ONE;
              end
            end
          end
          S_DONE: ;
        endcase
      end
    end
  end

  always_comb begin
    done   = '0;
    active = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      done[i] = (state_q[i] == S_DONE);
      if (state_q[i] != S_IDLE && state_q[i] != S_DONE) active = 1'b1;
    end
  end

`ifdef STIM_SCHED_OVERRUN_EN
  logic [N_CH-1:0] ovr_q;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      ovr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if ((state_q[i] == S_PEND || (state_q[i] == S_ISSUE && !load_q[i])) &&
            tick && cnt_q[i] <= ONE)
          ovr_q[i] <= 1'b1;
      end
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = '0;
`endif
endmodule
